magnetron_controle: RTL and testbench

//  Run/pause/done control FSM that fills the magnetron-control slot of the microwave top level.

---
 rtl/magnetron_controle_pkg.sv | 16 +
 rtl/magnetron_controle_botao_debounce.sv | 58 +++++
 rtl/magnetron_controle.sv | 160 ++++++++++++++++
 tb/tb_magnetron_controle.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/magnetron_controle_pkg.sv
// Shared definitions for the magnetron run/pause/done controller.
package magnetron_controle_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    // Bits needed to hold 0..max_val. A zero maximum still gets one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/magnetron_controle_botao_debounce.sv
// Button/door conditioning: 2-FF synchronizer, stable-sample debouncer and press pulse.
module magnetron_controle_botao_debounce
    import magnetron_controle_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw_i,
    output logic level_o,  // debounced level as it will be after the next edge
    output logic fall_o    // one-cycle pulse on the debounced 1->0 edge
);

    localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            fall_q, fall_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state and press pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            level_q <= RESET_LEVEL;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_d;
    assign fall_o  = fall_q;

endmodule

// File: rtl/magnetron_controle.sv
// Microwave magnetron control: run/pause/done FSM, done-beep timing and timer clear request.
module magnetron_controle
    import magnetron_controle_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned BEEP_SECS       = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic startn,
    input  logic stopn,
    input  logic clearn,
    input  logic door_closed,
    input  logic timer_zero,
    input  logic pgt_1Hz,
    output logic enablen,
    output logic mag_on,
    output logic beep,
    output logic clear_timern
);

    localparam int unsigned      BeepW    = cnt_width(BEEP_SECS);
    localparam logic [BeepW-1:0] BeepMax  = BeepW'(BEEP_SECS);
    localparam logic [BeepW-1:0] BeepLast = BeepW'((BEEP_SECS > 0) ? BEEP_SECS - 1 : 0);

    logic start_ev, stop_ev, clear_ev, door_ok;
    logic start_lvl, stop_lvl, clear_lvl, door_fall;

    magnetron_controle_botao_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b1)
    ) u_start (
        .clk    (clk),
        .resetn (resetn),
        .raw_i  (startn),
        .level_o(start_lvl),
        .fall_o (start_ev)
    );

    magnetron_controle_botao_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b1)
    ) u_stop (
        .clk    (clk),
        .resetn (resetn),
        .raw_i  (stopn),
        .level_o(stop_lvl),
        .fall_o (stop_ev)
    );

    magnetron_controle_botao_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b1)
    ) u_clear (
        .clk    (clk),
        .resetn (resetn),
        .raw_i  (clearn),
        .level_o(clear_lvl),
        .fall_o (clear_ev)
    );

    // Door uses the look-ahead level so mag_on falls on the same edge the debounced door opens.
    magnetron_controle_botao_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (1'b0)
    ) u_door (
        .clk    (clk),
        .resetn (resetn),
        .raw_i  (door_closed),
        .level_o(door_ok),
        .fall_o (door_fall)
    );

    logic unused_debounce;
    assign unused_debounce = ^{start_lvl, stop_lvl, clear_lvl, door_fall};

    state_e           state_q, state_d;
    logic [BeepW-1:0] beep_cnt_q, beep_cnt_d;
    logic             clr;
    logic             enablen_d, mag_on_d, beep_d, clear_timern_d;

    // Next state, clear request and the saturating beep counter (zero outside DONE).
    always_comb begin
        state_d    = state_q;
        clr        = 1'b0;
        beep_cnt_d = '0;
        unique case (state_q)
            StIdle: begin
                if (clear_ev) begin
                    clr = 1'b1;
                end else if (start_ev && door_ok && !timer_zero) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (clear_ev) begin
                    state_d = StIdle;
                    clr     = 1'b1;
                end else if (timer_zero) begin
                    state_d = StDone;
                end else if (!door_ok || stop_ev) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (clear_ev || stop_ev) begin
                    state_d = StIdle;
                    clr     = 1'b1;
                end else if (start_ev && door_ok && !timer_zero) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                beep_cnt_d = beep_cnt_q;
                if (pgt_1Hz && beep_cnt_q != BeepMax) begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                end
                if (clear_ev) begin
                    state_d = StIdle;
                    clr     = 1'b1;
                end else if (BEEP_SECS == 0) begin
                    state_d = StIdle;
                end else if (start_ev || stop_ev || !door_ok) begin
                    state_d = StIdle;
                end else if (pgt_1Hz && beep_cnt_q == BeepLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        enablen_d      = (state_d != StRun);
        mag_on_d       = (state_d == StRun);
        beep_d         = (state_d == StDone);
        clear_timern_d = ~clr;
    end

    // State, beep counter and output registers; reset drops mag_on immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            beep_cnt_q   <= '0;
            enablen      <= 1'b1;
            mag_on       <= 1'b0;
            beep         <= 1'b0;
            clear_timern <= 1'b1;
        end else begin
            state_q      <= state_d;
            beep_cnt_q   <= beep_cnt_d;
            enablen      <= enablen_d;
            mag_on       <= mag_on_d;
            beep         <= beep_d;
            clear_timern <= clear_timern_d;
        end
    end

endmodule

// File: tb/tb_magnetron_controle.sv
// Self-checking bench for magnetron_controle: directed table, corner sequences, random vs model.
module tb_magnetron_controle;

    localparam int unsigned DEB  = 4;
    localparam int unsigned BEEP = 2;

    logic clk = 1'b0;
    logic resetn, startn, stopn, clearn, door_closed, timer_zero, pgt_1Hz;
    logic enablen, mag_on, beep, clear_timern;

    always #5 clk = ~clk;

    magnetron_controle #(
        .DEBOUNCE_CYCLES(DEB),
        .BEEP_SECS      (BEEP)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .pgt_1Hz     (pgt_1Hz),
        .enablen     (enablen),
        .mag_on      (mag_on),
        .beep        (beep),
        .clear_timern(clear_timern)
    );

    typedef enum int {ActStart, ActStop, ActClear, ActDoor, ActTz, ActPgt} act_e;

    typedef struct {
        act_e act;
        bit   arg;
        bit   en;
        bit   mag;
        bit   bp;
        int   clr;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Clear-pulse monitor and mag_on/enablen consistency watch.
    int clr_seen = 0;
    bit clr_prev = 1'b0;
    bit clr_long = 1'b0;
    int inv_bad  = 0;

    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (clear_timern === 1'b0) begin
                clr_seen++;
                if (clr_prev) clr_long = 1'b1;
            end
            clr_prev = (clear_timern === 1'b0);
            if (mag_on === 1'b1 && enablen !== 1'b0) inv_bad++;
        end else begin
            clr_prev = 1'b0;
        end
    end

    // Reference model: cooking / paused / beeping flags plus seconds of beep left.
    bit m_run, m_pause, m_beep, m_door, m_tz;
    int m_left, m_clr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input act_e a, input bit arg);
        case (a)
            ActStart: begin startn = 1'b0; wait_cyc(10); startn = 1'b1; wait_cyc(10); end
            ActStop:  begin stopn  = 1'b0; wait_cyc(10); stopn  = 1'b1; wait_cyc(10); end
            ActClear: begin clearn = 1'b0; wait_cyc(10); clearn = 1'b1; wait_cyc(10); end
            ActDoor:  begin door_closed = arg; wait_cyc(12); end
            ActTz:    begin timer_zero = arg; wait_cyc(3); end
            default:  begin pgt_1Hz = 1'b1; wait_cyc(1); pgt_1Hz = 1'b0; wait_cyc(2); end
        endcase
    endtask

    task automatic model_apply(input act_e a, input bit arg);
        case (a)
            ActStart: begin
                if (m_beep) m_beep = 1'b0;
                else if (!m_run && m_door && !m_tz) begin m_run = 1'b1; m_pause = 1'b0; end
            end
            ActStop: begin
                if (m_beep) m_beep = 1'b0;
                else if (m_run) begin m_run = 1'b0; m_pause = 1'b1; end
                else if (m_pause) begin m_pause = 1'b0; m_clr++; end
            end
            ActClear: begin
                m_run = 1'b0; m_pause = 1'b0; m_beep = 1'b0; m_clr++;
            end
            ActDoor: begin
                m_door = arg;
                if (!arg) begin
                    if (m_run) begin m_run = 1'b0; m_pause = 1'b1; end
                    m_beep = 1'b0;
                end
            end
            ActTz: begin
                m_tz = arg;
                if (arg && m_run) begin m_run = 1'b0; m_beep = 1'b1; m_left = BEEP; end
            end
            default: begin
                if (m_beep) begin
                    m_left--;
                    if (m_left == 0) m_beep = 1'b0;
                end
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   clr_base;
        int   lat;

        // Reset held with every input asserted.
        resetn = 1'b0; startn = 1'b0; stopn = 1'b0; clearn = 1'b0;
        door_closed = 1'b1; timer_zero = 1'b0; pgt_1Hz = 1'b1;
        wait_cyc(5);
        check("reset_enablen", enablen, 1);
        check("reset_mag_on", mag_on, 0);
        check("reset_beep", beep, 0);
        check("reset_clear_timern", clear_timern, 1);
        startn = 1'b1; stopn = 1'b1; clearn = 1'b1; pgt_1Hz = 1'b0;
        wait_cyc(1);
        resetn = 1'b1;
        wait_cyc(20);
        check("post_reset_idle", enablen, 1);
        check("post_reset_no_clear", clr_seen, 0);

        // Directed walk through the spec scenarios.
        tbl.push_back('{ActTz,    1'b0, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{ActClear, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        tbl.push_back('{ActStart, 1'b0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{ActDoor,  1'b0, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{ActStart, 1'b0, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{ActDoor,  1'b1, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{ActStart, 1'b0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{ActTz,    1'b1, 1'b1, 1'b0, 1'b1, 0});
        tbl.push_back('{ActPgt,   1'b0, 1'b1, 1'b0, 1'b1, 0});
        tbl.push_back('{ActPgt,   1'b0, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{ActStart, 1'b0, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{ActTz,    1'b0, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{ActStart, 1'b0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{ActStop,  1'b0, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{ActStop,  1'b0, 1'b1, 1'b0, 1'b0, 1});
        tbl.push_back('{ActStart, 1'b0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{ActClear, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        tbl.push_back('{ActStart, 1'b0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{ActTz,    1'b1, 1'b1, 1'b0, 1'b1, 0});
        tbl.push_back('{ActDoor,  1'b0, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{ActDoor,  1'b1, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{ActTz,    1'b0, 1'b1, 1'b0, 1'b0, 0});
        tbl.push_back('{ActStart, 1'b0, 1'b0, 1'b1, 1'b0, 0});
        tbl.push_back('{ActTz,    1'b1, 1'b1, 1'b0, 1'b1, 0});
        tbl.push_back('{ActClear, 1'b0, 1'b1, 1'b0, 1'b0, 1});
        tbl.push_back('{ActTz,    1'b0, 1'b1, 1'b0, 1'b0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            clr_base = clr_seen;
            drive(tbl[i].act, tbl[i].arg);
            check($sformatf("tbl%0d_enablen", i), enablen, tbl[i].en);
            check($sformatf("tbl%0d_mag_on", i), mag_on, tbl[i].mag);
            check($sformatf("tbl%0d_beep", i), beep, tbl[i].bp);
            check($sformatf("tbl%0d_clear_pulses", i), clr_seen - clr_base, tbl[i].clr);
        end

        // Short glitch on start must not start cooking.
        startn = 1'b0; wait_cyc(3); startn = 1'b1; wait_cyc(12);
        check("glitch_no_run", enablen, 1);

        // Start latency: 2 sync + 4 debounce + 1 output register.
        lat = 0;
        startn = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (enablen === 1'b0 && lat == 0) lat = k;
        end
        check("start_latency", lat, 7);
        check("start_mag_on", mag_on, 1);
        startn = 1'b1; wait_cyc(10);
        check("held_start_still_run", enablen, 0);

        // Stop event and timer_zero in the same cycle: DONE wins.
        stopn = 1'b0; wait_cyc(6);
        timer_zero = 1'b1; wait_cyc(1);
        check("done_wins_beep", beep, 1);
        check("done_wins_mag_off", mag_on, 0);
        stopn = 1'b1; wait_cyc(10);
        check("done_hold_beep", beep, 1);
        drive(ActPgt, 1'b0);
        drive(ActPgt, 1'b0);
        check("done_expired_beep", beep, 0);
        check("done_expired_idle", enablen, 1);
        drive(ActTz, 1'b0);

        // Reset while cooking: mag_on drops before the next clock edge.
        drive(ActStart, 1'b0);
        check("pre_reset_run", mag_on, 1);
        clr_base = clr_seen;
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("async_reset_mag_on", mag_on, 0);
        check("async_reset_enablen", enablen, 1);
        wait_cyc(3);
        resetn = 1'b1;
        wait_cyc(20);
        check("after_reset_idle", enablen, 1);
        check("after_reset_no_beep", beep, 0);
        check("after_reset_no_clear", clr_seen - clr_base, 0);

        // Randomized actions checked against the reference model.
        m_run = 1'b0; m_pause = 1'b0; m_beep = 1'b0; m_left = 0;
        m_door = 1'b1; m_tz = 1'b0; m_clr = clr_seen;
        for (int n = 0; n < 150; n++) begin
            int   r;
            act_e a;
            bit   arg;
            r   = $urandom_range(0, 99);
            arg = 1'($urandom_range(0, 1));
            if (r < 25)      a = ActStart;
            else if (r < 40) a = ActStop;
            else if (r < 48) a = ActClear;
            else if (r < 62) a = ActDoor;
            else if (r < 80) a = ActTz;
            else             a = ActPgt;
            drive(a, arg);
            model_apply(a, arg);
            check($sformatf("rnd%0d_enablen", n), enablen, !m_run);
            check($sformatf("rnd%0d_mag_on", n), mag_on, m_run);
            check($sformatf("rnd%0d_beep", n), beep, m_beep);
            check($sformatf("rnd%0d_clear_pulses", n), clr_seen, m_clr);
        end

        check("clear_pulse_single_cycle", clr_long, 0);
        check("mag_on_implies_enabled", inv_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
